// File: rtl/rep3_pkg.sv
// rtl/rep3_pkg.sv - shared state type and repetition factor for the rep3 serial link
package rep3_pkg;

  typedef enum logic {IDLE, SEND} rep3_state_t;

  // Also used by the receiver-side voter wrapper; both ends must agree.
  localparam int REP_COUNT = 3;

endpackage

// File: rtl/rep3_sym_counter.sv
// rtl/rep3_sym_counter.sv - modulo-3 sample counter with enable, clear and last_rep flag
module rep3_sym_counter
  import rep3_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] count,
  output logic       last_rep
);

  assign last_rep = (count == 2'(REP_COUNT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= last_rep ? 2'd0 : count + 2'd1;
    end
  end

endmodule

// File: rtl/rep3_tx.sv
// rtl/rep3_tx.sv - triple-repetition LSB-first serial transmitter with valid/ready word input
// Optional even-parity bit appended after the MSB when REP3_TX_PARITY_EN is defined.
module rep3_tx
  import rep3_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             tx_out,
  output logic             tx_valid,
  output logic             done
);

`ifdef REP3_TX_PARITY_EN
  localparam int FRAME_BITS = WIDTH + 1;
`else
  localparam int FRAME_BITS = WIDTH;
`endif
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  rep3_state_t           state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [1:0]            rep_cnt;
  logic                  last_rep;
  logic                  sending;
  logic                  frame_end;
  logic                  accept;

  assign sending   = (state == SEND);
  // Last sample of the last bit: frame closes here and a new word may be taken.
  assign frame_end = sending && (bit_cnt == LAST_BIT) && (rep_cnt == 2'd2);
  assign ready_out = (state == IDLE) || frame_end;
  assign accept    = valid_in && ready_out;

  rep3_sym_counter u_rep_cnt (
    .clk      (clk),
    .rst      (rst),
    .en       (sending),
    .clr      (accept),
    .count    (rep_cnt),
    .last_rep (last_rep)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    if (accept) begin
      state_n   = SEND;
      bit_cnt_n = '0;
`ifdef REP3_TX_PARITY_EN
      shreg_n   = {^data_in, data_in};
`else
      shreg_n   = data_in;
`endif
    end else if (sending && last_rep) begin
      shreg_n = shreg >> 1;
      if (frame_end) begin
        state_n   = IDLE;
        bit_cnt_n = '0;
      end else begin
        bit_cnt_n = bit_cnt + BW'(1);
      end
    end
  end

  // Outputs are registered from next-state values so a word accepted at an
  // edge puts its first sample on the line right after that same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      bit_cnt  <= '0;
      tx_out   <= 1'b0;
      tx_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      shreg    <= shreg_n;
      bit_cnt  <= bit_cnt_n;
      tx_out   <= (state_n == SEND) && shreg_n[0];
      tx_valid <= (state_n == SEND);
      done     <= frame_end;
    end
  end

endmodule

// File: tb/tb_rep3_tx.sv
// tb/tb_rep3_tx.sv - scoreboard bench for rep3_tx (parity checks active with REP3_TX_PARITY_EN)
module tb_rep3_tx;

  localparam int WIDTH = 8;
`ifdef REP3_TX_PARITY_EN
  localparam int FB = WIDTH + 1;
`else
  localparam int FB = WIDTH;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] data_in = '0;
  logic             valid_in = 1'b0;
  logic             ready_out;
  logic             tx_out;
  logic             tx_valid;
  logic             done;

  rep3_tx #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .tx_out    (tx_out),
    .tx_valid  (tx_valid),
    .done      (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int exp_q[$];
  int done_q[$];
  int cap_q[$];
  bit capture = 1'b0;
  int valid_run = 0;
  int max_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every line sample and every done pulse is popped here.
  always @(negedge clk) begin : monitor
    int e;
    if (!rst) begin
      if (tx_valid === 1'b1) begin
        valid_run = valid_run + 1;
        if (valid_run > max_run) max_run = valid_run;
        if (capture) cap_q.push_back(int'(tx_out));
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_sample cyc=%0d tx_out=%b required=no sample", cyc, tx_out);
        end else begin
          e = exp_q.pop_front();
          if (tx_out !== e[0]) begin
            failures++;
            $display("FAIL sample cyc=%0d tx_out=%b required=%b", cyc, tx_out, e[0]);
          end
        end
      end else begin
        valid_run = 0;
        checks++;
        if (tx_valid !== 1'b0 || tx_out !== 1'b0) begin
          failures++;
          $display("FAIL idle_line cyc=%0d tx_valid=%b tx_out=%b required=0/0", cyc, tx_valid, tx_out);
        end
      end
      if (done === 1'b1) begin
        checks++;
        if (done_q.size() > 0 && done_q[0] == cyc) begin
          void'(done_q.pop_front());
        end else begin
          failures++;
          $display("FAIL done_pulse cyc=%0d done=1 required=0", cyc);
        end
      end else if (done_q.size() > 0 && done_q[0] <= cyc) begin
        checks++;
        failures++;
        $display("FAIL done_missing cyc=%0d done=%b required=1", cyc, done);
        void'(done_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d required=finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic push_frame(input logic [WIDTH-1:0] d, input int acc_cyc);
    logic b;
    for (int i = 0; i < FB; i++) begin
      b = (i < WIDTH) ? d[i] : ^d;
      for (int r = 0; r < 3; r++) exp_q.push_back(int'(b));
    end
    done_q.push_back(acc_cyc + 3 * FB);
  endtask

  task automatic send_word(input logic [WIDTH-1:0] d);
    int n = 0;
    @(negedge clk); #1;
    data_in  = d;
    valid_in = 1'b1;
    while (ready_out !== 1'b1 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (n == 200) begin
      checks++;
      failures++;
      $display("FAIL send_timeout ready_out=%b required=1", ready_out);
    end
    push_frame(d, cyc + 1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    data_in  = WIDTH'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && n < 500) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (n == 500) begin
      failures++;
      $display("FAIL drain_timeout pending=%0d required=0", exp_q.size() + done_q.size());
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({tx_out, tx_valid, done, ready_out} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_in tx_out/tx_valid/done/ready=%b required=0001", {tx_out, tx_valid, done, ready_out});
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({tx_out, tx_valid, done, ready_out} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_out tx_out/tx_valid/done/ready=%b required=0001", {tx_out, tx_valid, done, ready_out});
    end
  endtask

  task automatic test_single();
    max_run = 0;
    send_word(8'hA5);
    wait_idle();
    checks++;
    if (max_run != 3 * FB) begin
      failures++;
      $display("FAIL single_valid_len got=%0d required=%0d", max_run, 3 * FB);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy;
    max_run = 0;
    @(negedge clk); #1;
    data_in  = 8'h01;
    valid_in = 1'b1;
    push_frame(8'h01, cyc + 1);
    @(posedge clk); #1;
    data_in = 8'h80;
    for (int k = 0; k < 3 * FB; k++) begin
      exp_rdy = (k == 3 * FB - 1);
      checks++;
      if (ready_out !== exp_rdy) begin
        failures++;
        $display("FAIL b2b_ready k=%0d ready_out=%b required=%b", k, ready_out, exp_rdy);
      end
      if (exp_rdy) push_frame(8'h80, cyc + 1);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    wait_idle();
    checks++;
    if (max_run != 6 * FB) begin
      failures++;
      $display("FAIL b2b_valid_len got=%0d required=%0d", max_run, 6 * FB);
    end
  endtask

  task automatic test_stall();
    send_word(8'h5A);
    for (int k = 1; k < 3 * FB - 1; k++) begin
      valid_in = k[0];
      data_in  = WIDTH'($urandom);
      checks++;
      if (ready_out !== 1'b0) begin
        failures++;
        $display("FAIL stall_ready k=%0d ready_out=%b required=0", k, ready_out);
      end
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    send_word(8'hFF);
    repeat (10) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tx_out, tx_valid, done, ready_out} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_mid tx_out/tx_valid/done/ready=%b required=0001", {tx_out, tx_valid, done, ready_out});
    end
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge clk);
    #2;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (ready_out !== 1'b1 || tx_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after ready_out=%b tx_valid=%b required=1/0", ready_out, tx_valid);
    end
  endtask

  task automatic test_loopback();
    logic [FB-1:0] rx;
    logic a, b, c;
    cap_q.delete();
    capture = 1'b1;
    send_word(8'h3C);
    wait_idle();
    capture = 1'b0;
    checks++;
    if (cap_q.size() != 3 * FB) begin
      failures++;
      $display("FAIL loop_len got=%0d required=%0d", cap_q.size(), 3 * FB);
    end else begin
      for (int g = 0; g < FB; g++) begin
        a = cap_q[3 * g][0]     ^ (g % 3 == 0);
        b = cap_q[3 * g + 1][0] ^ (g % 3 == 1);
        c = cap_q[3 * g + 2][0] ^ (g % 3 == 2);
        rx[g] = (a & b) | (a & c) | (b & c);
      end
      checks++;
      if (rx[WIDTH-1:0] !== 8'h3C) begin
        failures++;
        $display("FAIL loopback got=%h required=3c", rx[WIDTH-1:0]);
      end
    end
  endtask

`ifdef REP3_TX_PARITY_EN
  task automatic test_parity(input logic [WIDTH-1:0] d, input int exp_par);
    cap_q.delete();
    capture = 1'b1;
    send_word(d);
    wait_idle();
    capture = 1'b0;
    checks++;
    if (cap_q.size() != 27 || cap_q[24] != exp_par || cap_q[25] != exp_par || cap_q[26] != exp_par) begin
      failures++;
      $display("FAIL parity data=%h samples=%0d required=27 with final group %0d", d, cap_q.size(), exp_par);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_loopback();
`ifdef REP3_TX_PARITY_EN
    test_parity(8'hA5, 0);
    test_parity(8'h07, 1);
`endif
    for (int i = 0; i < 4; i++) begin
      send_word(WIDTH'($urandom));
      wait_idle();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rep3_tx.md
# rep3_tx

Serial triple-repetition transmitter: accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, driving each bit on the line for three consecutive clock cycles. It is the sending end of the majority-vote link. The receiver votes each 3-sample group with the 2-of-3 majority cell, so any single corrupted sample per bit is corrected. It sits between a word producer (register file or test driver) and the single-bit serial line.

## Interface
- WIDTH, 8, data word width in bits; legal range 1..32
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- data_in  input  WIDTH  word to transmit; sampled on an accepted handshake
- valid_in  input  1  producer has a word
- ready_out  output  1  block can accept a word this cycle
- tx_out  output  1  serial line, registered
- tx_valid  output  1  high while tx_out carries frame samples, registered
- done  output  1  one-cycle pulse, registered, in the cycle after the last sample of a frame

## Operation
- States: IDLE and SEND, held in a registered enum.
- Accept: a word is accepted when valid_in & ready_out are both high at a rising edge.
- ready_out = (state==IDLE) | (state==SEND & last_bit & rep_cnt==2). The last-sample cycle also accepts, so frames can run back-to-back with no gap.
- On accept:
  - Load the shift register with data_in (plus the parity bit if enabled).
  - Clear bit_cnt and rep_cnt.
  - Go to (or stay in) SEND.
- In SEND:
  - tx_out = shreg[0] and tx_valid = 1.
  - rep_cnt counts 0,1,2. On the 2→0 wrap, shift right by one and increment bit_cnt.
- Frame end: after the last bit's rep_cnt==2 cycle:
  - With no new accept, go to IDLE and pulse done.
  - With a simultaneous accept, pulse done and start the new frame in the next cycle.
- IDLE: tx_out=0, tx_valid=0, and valid_in is ignored unless ready_out is high.
- bit_cnt is $clog2(WIDTH+1) bits wide. rep_cnt is 2 bits wide and never reaches 3.
- data_in changes while SEND is active have no effect on the current frame.

## Timing
- Reset values: state=IDLE, tx_out=0, tx_valid=0, done=0, ready_out=1, all counters and shreg = 0.
- Reset mid-frame aborts the frame immediately, with no done pulse.
- Latency: accept at edge N → first sample visible after edge N, for 3·FRAME_BITS cycles.
  - FRAME_BITS = WIDTH, or WIDTH+1 with parity enabled.
- Back-to-back accepts give a continuous stream: tx_valid stays high with no idle cycle.

## Configuration
- REP3_TX_PARITY_EN: when defined, an even-parity bit (XOR of data_in) is appended after the MSB and is also repeated three times, so a frame is 3·(WIDTH+1) cycles.
- Undefined: a frame is 3·WIDTH cycles with no parity logic.

## Structure
- rep3_pkg holds:
  - typedef enum logic {IDLE, SEND} rep3_state_t
  - localparam REP_COUNT = 3, shared with the receiver-side voter wrapper
- One natural sub-module, rep3_sym_counter: a modulo-3 counter with enable, clear and a last_rep output. It is instantiated once for rep_cnt.

## Test plan
- Reset: assert rst mid-frame of 0xFF → tx_out=0, tx_valid=0 and ready_out=1 immediately; no done pulse.
- WIDTH=8, send 0xA5 → tx_out = 111 000 111 000 000 111 000 111 over 24 cycles, tx_valid high for exactly 24 cycles, done pulses in cycle 25.
- Back-to-back: 0x01 then 0x80, with valid_in held high →
  - ready_out high only in the last sample cycle.
  - 48 contiguous tx_valid cycles.
  - Stream is 111 then 21×0 for the first word, then 21×0 then 111 for the second.
- Stall: valid_in toggled mid-frame with changing data_in → frame content unchanged; no second accept until ready_out rises.
- REP3_TX_PARITY_EN, send 0xA5 → 27 samples, final group 000 (even parity); send 0x07 → final group 111.
- Loopback through three majority voters, one sample per group forced inverted for 0x3C → receiver reconstructs 0x3C.
